// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locking arbiter sharing one async-FIFO write port among NREQ
// valid/ready requesters; every output word is tagged with its source index.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int NDATABITS = 32,
    parameter int NIDBITS   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NREQ*NDATABITS-1:0]    inData_i,
    input  logic [NREQ-1:0]              inValid_i,
    input  logic [NREQ-1:0]              inLast_i,
    output logic [NREQ-1:0]              inReady_o,
    input  logic [NREQ-1:0]              reqMask_i,
    output logic [NIDBITS+NDATABITS-1:0] outData_o,
    output logic                         outValid_o,
    input  logic                         outReady_i,
    output logic                         outLast_o,
    output logic [NREQ-1:0]              grant_o,
    output logic                         busy_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   g, g_next;
    logic [PW-1:0]   rr_ptr, rr_ptr_next;
    logic [NREQ-1:0] grant, grant_next;
    logic [NREQ-1:0] cand;
    logic            found;
    logic [PW-1:0]   pick;
    logic [PW:0]     sum;
    logic            end_of_packet;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state  <= state_next;
            g      <= g_next;
            rr_ptr <= rr_ptr_next;
            grant  <= grant_next;
        end
    end

    // Rotating search from rr_ptr; the one-bit-wider sum keeps the wrap modulo NREQ.
    always_comb begin
        cand  = inValid_i & reqMask_i;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            if (!found && cand[sum[PW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PW-1:0];
            end
        end
    end

    assign end_of_packet = (state == LOCKED) && inValid_i[g] && outReady_i && inLast_i[g];

    always_comb begin
        state_next  = state;
        g_next      = g;
        rr_ptr_next = rr_ptr;
        grant_next  = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = LOCKED;
                    g_next     = pick;
                    grant_next = NREQ'(1) << pick;
                end
            end
            LOCKED: begin
                if (end_of_packet) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = (g == PW'(NREQ-1)) ? '0 : g + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on the registered grant plus the granted requester's inputs.
    always_comb begin
        outValid_o = 1'b0;
        outLast_o  = 1'b0;
        inReady_o  = '0;
        outData_o  = {NIDBITS'(g), inData_i[int'(g)*NDATABITS +: NDATABITS]};
        if (state == LOCKED) begin
            outValid_o   = inValid_i[g];
            outLast_o    = inLast_i[g];
            inReady_o[g] = outReady_i;
        end
    end

    assign grant_o = grant;
    assign busy_o  = (state == LOCKED);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-requester packet sources, a spec-level arbitration
// model checked every cycle, and directed plus randomized scenarios.
module tb_fifo_write_arbiter;
    localparam int NREQ      = 4;
    localparam int NDATABITS = 32;
    localparam int NIDBITS   = 2;
    localparam int OW        = NIDBITS + NDATABITS;
    localparam int DEPTH     = 512;

    logic                      clk = 1'b0;
    logic                      rst_i;
    logic [NREQ*NDATABITS-1:0] inData_i;
    logic [NREQ-1:0]           inValid_i, inLast_i, inReady_o, reqMask_i, grant_o;
    logic [OW-1:0]             outData_o;
    logic                      outValid_o, outReady_i, outLast_o, busy_o;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NREQ(NREQ), .NDATABITS(NDATABITS), .NIDBITS(NIDBITS)) dut (
        .clk_i(clk), .rst_i(rst_i), .inData_i(inData_i), .inValid_i(inValid_i),
        .inLast_i(inLast_i), .inReady_o(inReady_o), .reqMask_i(reqMask_i),
        .outData_o(outData_o), .outValid_o(outValid_o), .outReady_i(outReady_i),
        .outLast_o(outLast_o), .grant_o(grant_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Requester sources: beats are {last, data}
    logic [NDATABITS:0] mem [NREQ][DEPTH];
    int unsigned        hd [NREQ];
    int unsigned        tl [NREQ];
    logic [NREQ-1:0]    ven;

    // Reference model of the arbitration rules
    int    m_busy, m_g, m_ptr;
    int    cyc_bad;
    string bad_msg;

    logic [OW:0] olog [$];
    logic [OW:0] plog [$];
    int          glog [$];
    logic        prev_busy;

    logic            ob_busy, ob_valid, ob_last;
    logic [NREQ-1:0] ob_grant, ob_ready;
    logic [OW-1:0]   ob_data;

    function automatic logic [NDATABITS:0] head(input int k);
        return mem[k][hd[k] % DEPTH];
    endfunction

    function automatic bit has(input int k);
        return hd[k] != tl[k];
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        if ($countones(v) != 1) return 99;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_packet(input int k, input int len);
        for (int b = 0; b < len; b++) begin
            mem[k][tl[k] % DEPTH] = {(b == len - 1), NDATABITS'($urandom)};
            tl[k]++;
        end
    endtask

    task automatic flush();
        for (int k = 0; k < NREQ; k++) hd[k] = tl[k];
    endtask

    task automatic drive();
        logic [NDATABITS:0] b;
        for (int k = 0; k < NREQ; k++) begin
            if (has(k)) begin
                b = head(k);
                inData_i[k*NDATABITS +: NDATABITS] = b[NDATABITS-1:0];
                inLast_i[k]  = b[NDATABITS];
                inValid_i[k] = ven[k];
            end else begin
                inData_i[k*NDATABITS +: NDATABITS] = NDATABITS'($urandom);
                inLast_i[k]  = 1'($urandom);
                inValid_i[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0]    sv_valid, sv_last, sv_mask, sv_ready, e_grant, e_ready;
        logic               sv_rst, sv_ordy, sv_oval, sv_olast, e_busy, e_valid, e_last;
        logic [OW-1:0]      sv_odata, e_data;
        logic [NDATABITS:0] b;
        bit                 hit;
        int                 idx;
        drive();
        #1;
        ob_busy = busy_o; ob_grant = grant_o; ob_valid = outValid_o;
        ob_ready = inReady_o; ob_data = outData_o; ob_last = outLast_o;
        e_busy = (m_busy != 0); e_grant = '0; e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_data = '0;
        if (m_busy != 0) begin
            b = head(m_g);
            e_grant[m_g] = 1'b1;
            e_ready[m_g] = outReady_i;
            e_valid      = inValid_i[m_g];
            e_last       = b[NDATABITS];
            e_data       = {NIDBITS'(m_g), b[NDATABITS-1:0]};
        end
        if ({ob_busy, ob_grant, ob_valid, ob_ready} !== {e_busy, e_grant, e_valid, e_ready} ||
            (e_valid && {ob_last, ob_data} !== {e_last, e_data})) begin
            cyc_bad++;
            bad_msg = $sformatf("t=%0t busy %b/%b grant %b/%b valid %b/%b ready %b/%b last %b/%b data %h/%h",
                                $time, ob_busy, e_busy, ob_grant, e_grant, ob_valid, e_valid,
                                ob_ready, e_ready, ob_last, e_last, ob_data, e_data);
        end
        if (ob_busy && !prev_busy) glog.push_back(onehot_idx(ob_grant));
        prev_busy = ob_busy;
        sv_valid = inValid_i; sv_last = inLast_i; sv_mask = reqMask_i; sv_ready = inReady_o;
        sv_rst = rst_i; sv_ordy = outReady_i; sv_oval = outValid_o; sv_odata = outData_o; sv_olast = outLast_o;
        @(posedge clk);
        if (sv_rst) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (m_busy == 0) begin
            hit = 1'b0;
            for (int j = 0; j < NREQ; j++) begin
                idx = (m_ptr + j) % NREQ;
                if (!hit && sv_valid[idx] && sv_mask[idx]) begin
                    hit = 1'b1;
                    m_g = idx;
                    m_busy = 1;
                end
            end
        end else if (sv_valid[m_g] && sv_ordy && sv_last[m_g]) begin
            m_busy = 0;
            m_ptr  = (m_g + 1) % NREQ;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (sv_valid[k] && sv_ready[k]) begin
                b = head(k);
                plog.push_back({b[NDATABITS], NIDBITS'(k), b[NDATABITS-1:0]});
                hd[k]++;
            end
        end
        if (sv_oval && sv_ordy) olog.push_back({sv_olast, sv_odata});
        #1;
    endtask

    task automatic do_reset();
        flush();
        ven   = '0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        prev_busy = 1'b0;
        olog.delete(); plog.delete(); glog.delete();
    endtask

    task automatic test_reset();
        int bad0 = cyc_bad;
        rst_i = 1'b1; reqMask_i = '1; outReady_i = 1'b1; ven = '1;
        for (int k = 0; k < NREQ; k++) push_packet(k, 2);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({ob_busy, ob_valid, ob_grant, ob_ready} !== '0)
                $display("FAIL reset_outputs: cycle %0d got busy=%b valid=%b grant=%b ready=%b, required all 0",
                         c, ob_busy, ob_valid, ob_grant, ob_ready);
            else n_pass++;
        end
        rst_i = 1'b0; glog.delete();
        for (int c = 0; c < 5 && glog.size() == 0; c++) tick();
        n_checks++;
        if (glog.size() < 1 || glog[0] != 0)
            $display("FAIL reset_first_grant: got %0d grants (first %0d), required first grant 0",
                     glog.size(), (glog.size() > 0) ? glog[0] : -1);
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_reset: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int          bad0 = cyc_bad;
        int          seq [5] = '{0, 1, 2, 3, 0};
        int          off [NREQ];
        logic [OW:0] exp [$];
        logic [NDATABITS:0] bt;
        int c = 0, bad = 0;
        do_reset();
        reqMask_i = '1; outReady_i = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            push_packet(k, 2); push_packet(k, 2); off[k] = 0;
        end
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 2; b++) begin
                bt = mem[seq[p]][(hd[seq[p]] + off[seq[p]]) % DEPTH];
                exp.push_back({bt[NDATABITS], NIDBITS'(seq[p]), bt[NDATABITS-1:0]});
                off[seq[p]]++;
            end
        end
        ven = '1;
        while (olog.size() < 10 && c < 40) begin tick(); c++; end
        n_checks++;
        if (c != 15) $display("FAIL rr_cycles: 10 beats took %0d cycles, required 15", c);
        else n_pass++;
        for (int i = 0; i < 5; i++) if (glog.size() < 5 || glog[i] != seq[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL rr_order: %0d grant order errors over %0d grants, required 0,1,2,3,0", bad, glog.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) if (olog.size() < 10 || olog[i] !== exp[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL rr_data: %0d word errors of 10, required 0", bad);
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_rr: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    task automatic test_packet_lock();
        int bad0 = cyc_bad;
        int gap = 0, early = 0, c = 0, bad = 0, popped;
        do_reset();
        reqMask_i = '1; outReady_i = 1'b1;
        push_packet(1, 5); push_packet(2, 3);
        ven = 4'b0110;
        while (has(1) && c < 60) begin
            popped = 5 - int'(tl[1] - hd[1]);
            ven[1] = !(popped == 2 && gap < 2);
            if (!ven[1]) gap++;
            tick();
            if (ob_ready[2]) early++;
            c++;
        end
        ven[1] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (early != 0) $display("FAIL lock_other_ready: requester 2 ready %0d cycles during lock, required 0", early);
        else n_pass++;
        for (int i = 0; i < 5; i++)
            if (olog.size() < 5 || olog[i][OW-1 -: NIDBITS] != NIDBITS'(1) || olog[i][OW] != (i == 4)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL lock_beats: %0d of 5 beats wrong id/last (log size %0d), required 0", bad, olog.size());
        else n_pass++;
        n_checks++;
        if (glog.size() < 2 || glog[0] != 1 || glog[1] != 2)
            $display("FAIL lock_grants: got %0d grants first %0d, required 1 then 2",
                     glog.size(), (glog.size() > 0) ? glog[0] : -1);
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_lock: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int            bad0 = cyc_bad;
        int            stall = 0, sbad = 0, c = 0, bad = 0, popped;
        logic [OW-1:0] held = '0;
        logic [OW:0]   exp [$];
        logic [NDATABITS:0] bt;
        do_reset();
        reqMask_i = '1; outReady_i = 1'b1;
        push_packet(0, 6);
        for (int i = 0; i < 6; i++) begin
            bt = mem[0][(hd[0] + i) % DEPTH];
            exp.push_back({bt[NDATABITS], NIDBITS'(0), bt[NDATABITS-1:0]});
        end
        ven = 4'b0001;
        while ((has(0) || stall < 4) && c < 60) begin
            popped = 6 - int'(tl[0] - hd[0]);
            outReady_i = !(popped == 2 && stall < 4);
            tick();
            if (!outReady_i) begin
                if (stall == 0) held = ob_data;
                else if (ob_data !== held || !ob_valid) sbad++;
                stall++;
            end
            c++;
        end
        outReady_i = 1'b1;
        tick(); tick();
        n_checks++;
        if (sbad != 0 || stall != 4) $display("FAIL bp_hold: %0d unstable stall cycles of %0d, required 0 of 4", sbad, stall);
        else n_pass++;
        for (int i = 0; i < 6; i++) if (olog.size() != 6 || olog[i] !== exp[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL bp_words: %0d word errors, %0d words out, required 0 errors 6 words", bad, olog.size());
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_bp: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    task automatic test_mask();
        int bad0 = cyc_bad;
        int c = 0, bad = 0;
        int seq [4] = '{1, 3, 1, 3};
        do_reset();
        reqMask_i = 4'b1010; outReady_i = 1'b1;
        for (int k = 0; k < NREQ; k++) for (int p = 0; p < 3; p++) push_packet(k, 2);
        ven = '1;
        while (glog.size() < 4 && c < 40) begin tick(); c++; end
        for (int i = 0; i < 4; i++) if (glog.size() < 4 || glog[i] != seq[i]) bad++;
        foreach (olog[i]) if (olog[i][OW-1 -: NIDBITS] == 0 || olog[i][OW-1 -: NIDBITS] == 2) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL mask_grants: %0d errors over %0d grants, required only 1,3,1,3", bad, glog.size());
        else n_pass++;
        do_reset();
        reqMask_i = 4'b1010;
        push_packet(1, 3); push_packet(3, 1);
        ven = 4'b1010; c = 0; bad = 0;
        while (olog.size() < 1 && c < 10) begin tick(); c++; end
        reqMask_i = 4'b1000; c = 0;
        while (olog.size() < 4 && c < 20) begin tick(); c++; end
        for (int i = 0; i < 3; i++)
            if (olog.size() < 4 || olog[i][OW-1 -: NIDBITS] != NIDBITS'(1) || olog[i][OW] != (i == 2)) bad++;
        if (olog.size() < 4 || olog[3][OW-1 -: NIDBITS] != NIDBITS'(3)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL mask_clear_midpkt: %0d errors, %0d words out, required 3 beats of id 1 then id 3", bad, olog.size());
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_mask: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int bad0 = cyc_bad;
        int c = 0;
        do_reset();
        reqMask_i = '1; outReady_i = 1'b1;
        push_packet(1, 1);
        ven = 4'b0010;
        while ((has(1) || busy_o) && c < 10) begin tick(); c++; end
        push_packet(2, 4);
        ven = 4'b0100; c = 0; olog.delete();
        while (olog.size() < 1 && c < 10) begin tick(); c++; end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flush(); prev_busy = 1'b0; glog.delete();
        push_packet(0, 2); push_packet(2, 2);
        ven = 4'b0101;
        tick();
        n_checks++;
        if ({ob_busy, ob_grant, ob_valid} !== '0)
            $display("FAIL midrst_idle: got busy=%b grant=%b valid=%b, required all 0", ob_busy, ob_grant, ob_valid);
        else n_pass++;
        c = 0;
        while (glog.size() < 1 && c < 5) begin tick(); c++; end
        n_checks++;
        if (glog.size() < 1 || glog[0] != 0)
            $display("FAIL midrst_first_grant: got %0d grants first %0d, required 0",
                     glog.size(), (glog.size() > 0) ? glog[0] : -1);
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_midrst: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad0 = cyc_bad;
        int bad = 0;
        do_reset();
        reqMask_i = '1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 49) == 0) reqMask_i = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                if (!has(k)) push_packet(k, $urandom_range(1, 4));
                ven[k] = ($urandom_range(0, 9) < 8);
            end
            outReady_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        n_checks++;
        if (olog.size() < 100) $display("FAIL rnd_progress: %0d words out, required at least 100", olog.size());
        else n_pass++;
        if (olog.size() != plog.size()) bad++;
        else foreach (olog[i]) if (olog[i] !== plog[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL rnd_stream: %0d mismatched words (out %0d, taken %0d), required 0", bad, olog.size(), plog.size());
        else n_pass++;
        bad = 0;
        for (int i = 1; i < olog.size(); i++)
            if (!olog[i-1][OW] && olog[i][OW-1 -: NIDBITS] != olog[i-1][OW-1 -: NIDBITS]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL rnd_interleave: %0d id switches inside a packet, required 0", bad);
        else n_pass++;
        n_checks++;
        if (cyc_bad != bad0) $display("FAIL model_rnd: %0d bad cycles, last %s", cyc_bad - bad0, bad_msg);
        else n_pass++;
    endtask

    initial begin
        cyc_bad = 0; m_busy = 0; m_g = 0; m_ptr = 0; prev_busy = 1'b0;
        for (int k = 0; k < NREQ; k++) begin hd[k] = 0; tl[k] = 0; end
        rst_i = 1'b1; ven = '0; reqMask_i = '1; outReady_i = 1'b1;
        drive();
        #1;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_mask();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin, packet-locking arbiter that lets NREQ valid/ready requesters share the single write port of one async FIFO. It sits entirely in the FIFO write-clock domain, directly in front of the FIFO write port. The arbiter grants one requester at a time and holds the grant until that requester's last beat. It prefixes each word with the source index so the read side can demultiplex.

## Interface
- NREQ, 4, number of requesters (2..16)
- NDATABITS, 32, payload width per requester
- NIDBITS, 2, source-index width; must satisfy 2^NIDBITS >= NREQ
- clk_i  in  1  write-side clock (FIFO write clock)
- rst_i  in  1  reset; synchronous, active-high
- inData_i  in  NREQ*NDATABITS  requester payloads; requester k at bits [k*NDATABITS +: NDATABITS]
- inValid_i  in  NREQ  per-requester valid
- inLast_i  in  NREQ  per-requester end-of-packet flag, qualified by inValid_i
- inReady_o  out  NREQ  per-requester ready
- reqMask_i  in  NREQ  1 = requester eligible for a new grant
- outData_o  out  NIDBITS+NDATABITS  {source index, payload}; goes to FIFO dataW_i
- outValid_o  out  1  goes to FIFO validW_i
- outReady_i  in  1  comes from FIFO readyW_o
- outLast_o  out  1  last flag of the granted requester
- grant_o  out  NREQ  one-hot registered grant; all zero when idle
- busy_o  out  1  1 while in LOCKED

## Operation
- A transfer on a port occurs when valid and ready are both 1 at a rising clk_i edge.
- State machine IDLE / LOCKED. Registered state: state, grant index g, rrPtr (next-priority index, width clog2(NREQ)).
- IDLE:
  - outValid_o=0; inReady_o all 0.
  - Candidates are requesters with inValid_i[k] & reqMask_i[k].
  - If any candidate exists: g <= first candidate found searching k = rrPtr, rrPtr+1, … mod NREQ. state <= LOCKED.
- LOCKED:
  - outValid_o = inValid_i[g].
  - inReady_o[g] = outReady_i; all other inReady_o bits are 0.
  - outData_o = {g, payload g}; outLast_o = inLast_i[g].
  - On a transfer with inLast_i[g]=1: rrPtr <= (g+1) mod NREQ, state <= IDLE.
  - Transfers without last keep the lock. A valid gap (inValid_i[g]=0) also keeps the lock.
- reqMask_i affects only new grants. Clearing the mask bit of the locked requester does not break the current packet.
- Requester indices at or above NREQ are never granted. The rrPtr wrap is computed modulo NREQ, not modulo 2^width.
- outValid_o, outLast_o and inReady_o are combinational from the registered grant. The only input-to-output paths are inValid_i/inData_i/inLast_i → out* and outReady_i → inReady_o. No path from inValid_i reaches inReady_o.
- outData_o is don't-care (may be x) when outValid_o=0.
- Reset, including mid-packet:
  - state=IDLE, rrPtr=0, grant_o=0, busy_o=0, outValid_o=0, inReady_o=0.
  - A partially sent packet is truncated. The downstream consumer is responsible for detecting this via a missing last.

## Timing
- Arbitration latency: first candidate valid in IDLE at edge n → grant_o/busy_o set after edge n → first beat can transfer at edge n+1.
- The packet-end transfer at edge m returns the arbiter to IDLE after m. The next grant is taken at edge m+1 and its first beat transfers at edge m+2. This gives exactly one bubble cycle between packets.
- Single-beat packet (last on first beat): 1 beat per 2 cycles maximum.
- Within a packet: 1 beat/cycle while inValid_i[g] and outReady_i are both 1.
- FIFO full (outReady_i=0): the beat is held, nothing is dropped, and the grant is unchanged.
- Simultaneous requests: exactly one grant, chosen by rrPtr order. A requester that has just finished has the lowest priority for the next grant.

## Test plan
- **Reset:** rst_i=1 for 3 cycles with all inValid_i=1 → outValid_o=0, inReady_o=0, grant_o=0, busy_o=0 throughout. After release, requester 0 is granted first.
- **Round robin:** NREQ=4, all mask=1, all four requesters present continuous 2-beat packets → grant sequence 0,1,2,3,0. Each packet transfers with {id,data} intact. There is exactly one idle cycle between packets.
- **Packet lock:** requester 1 sends a 5-beat packet with inValid_i[1] low on beat 3 for 2 cycles, while requester 2 valid throughout → requester 2 is never ready until requester 1's last transfers. outData_o[NDATABITS +: NIDBITS]=1 for all 5 beats.
- **Backpressure:** outReady_i=0 for 4 cycles mid-packet → beat held stable, no duplicate or lost words; scoreboard counts match exactly.
- **Mask:** reqMask_i=4'b1010, all valid → only requesters 1 and 3 are granted, alternating. Clearing bit 1 mid-packet of requester 1 → that packet still completes.
- **Reset mid-packet:** rst_i asserted on beat 2 of a 4-beat packet from requester 2 → the next edge is IDLE with rrPtr=0. With requesters 0 and 2 valid afterwards, requester 0 is granted first.
